// File: rtl/regfile_write_queue.sv
// Write-back queue in front of the 32-entry register file's single write port.
// It buffers retiring (rd, data) pairs, drains one per cycle and forwards pending writes to decode.
module regfile_write_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            wb_stall,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      fwd_addr1,
  input  logic [4:0]      fwd_addr2,
  output logic            fwd_hit1,
  output logic [XLEN-1:0] fwd_data1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data2,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            not_empty;
  logic            pop;
  logic            push;

  assign not_empty = (count != '0);
  assign pop       = not_empty && !wb_stall && !flush;
  assign in_ready  = !flush && ((count < FULL_COUNT) || pop);
  // A write to x0 completes its handshake but never occupies a slot.
  assign push      = in_valid && in_ready && (in_rd != 5'd0);

  assign rf_we    = pop;
  assign rf_waddr = not_empty ? rd_mem[rd_ptr]   : 5'd0;
  assign rf_wdata = not_empty ? data_mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage has no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Scan oldest to youngest so a later match overwrites an earlier one.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((AW+1)'(i) < count) begin
        if ((fwd_addr1 != 5'd0) && (rd_mem[idx] == fwd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end
        if ((fwd_addr2 != 5'd0) && (rd_mem[idx] == fwd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end
      end
    end
  end

endmodule
